// File: rtl/cmd_trig_gen.sv
// cmd_trig_gen: command-driven multi-channel trigger generator.
//   A rising edge on rx_rdy accepts the command word on rx_out.
//   Command word: [CMD_W-1:CMD_W-2] opcode, [CH_W-1:0] channel, other bits ignored.
//     00 stop channel, 01 single-shot, 10 continuous, 11 stop all.
//   Ports:
//     clk, rst      clock; asynchronous active-low reset
//     rx_rdy        receiver data-ready level (rising edge = new command)
//     rx_out        command word, valid in the cycle rx_rdy rises
//     trig[N_CH]    registered per-channel trigger outputs
//     busy[N_CH]    channel not idle
//     cmd_ack       one-cycle pulse per accepted command
//     cmd_err       one-cycle pulse per command naming a nonexistent channel
//   CMD_W must be at least CH_W+2.

// Per-channel trigger FSM with one shared down-counter.
module cmd_trig_ch #(
    parameter int PULSE_LEN = 1024,
    parameter int HIGH_LEN  = 1024,
    parameter int LOW_LEN   = 2**28,
    parameter int CNT_W     = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic shot,
    input  logic cont,
    input  logic stop,
    output logic trig,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, SHOT, CHI, CLO} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            trig  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            // trig follows the next state so it is a flop, not decode logic
            trig  <= (state_n == SHOT) || (state_n == CHI);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        // Commands win over a same-cycle counter expiry.
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (shot) begin
            state_n = SHOT;
            cnt_n   = CNT_W'(PULSE_LEN - 1);
        end else if (cont) begin
            state_n = CHI;
            cnt_n   = CNT_W'(HIGH_LEN - 1);
        end else begin
            case (state)
                SHOT: begin
                    if (cnt == '0) state_n = IDLE;
                    else           cnt_n   = cnt - CNT_W'(1);
                end
                CHI: begin
                    if (cnt == '0) begin
                        state_n = CLO;
                        cnt_n   = CNT_W'(LOW_LEN - 1);
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                CLO: begin
                    if (cnt == '0) begin
                        state_n = CHI;
                        cnt_n   = CNT_W'(HIGH_LEN - 1);
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

module cmd_trig_gen #(
    parameter int CMD_W     = 8,
    parameter int N_CH      = 4,
    parameter int PULSE_LEN = 1024,
    parameter int HIGH_LEN  = 1024,
    parameter int LOW_LEN   = 2**28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_rdy,
    input  logic [CMD_W-1:0] rx_out,
    output logic [N_CH-1:0]  trig,
    output logic [N_CH-1:0]  busy,
    output logic             cmd_ack,
    output logic             cmd_err
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MAX_PH  = (PULSE_LEN > HIGH_LEN) ? PULSE_LEN : HIGH_LEN;
    localparam int MAX_LEN = (MAX_PH > LOW_LEN) ? MAX_PH : LOW_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic            d_rdy;
    logic            accept;
    logic            bad_ch;
    logic            take;
    logic [1:0]      op;
    logic [CH_W-1:0] ch;

    assign op     = rx_out[CMD_W-1 -: 2];
    assign ch     = rx_out[CH_W-1:0];
    // d_rdy resets high so a level already present at reset release is ignored
    assign accept = rx_rdy & ~d_rdy;

    // Out-of-range channel is only possible when N_CH is not a power of two.
    if ((1 << CH_W) > N_CH) begin : g_range
        assign bad_ch = (op != 2'b11) && (ch >= CH_W'(N_CH));
    end else begin : g_norange
        assign bad_ch = 1'b0;
    end

    if (CMD_W > CH_W + 2) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^rx_out[CMD_W-3:CH_W];
    end

    assign take = accept & ~bad_ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_rdy   <= 1'b1;
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            d_rdy   <= rx_rdy;
            cmd_ack <= take;
            cmd_err <= accept & bad_ch;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = (ch == CH_W'(i));

        cmd_trig_ch #(
            .PULSE_LEN (PULSE_LEN),
            .HIGH_LEN  (HIGH_LEN),
            .LOW_LEN   (LOW_LEN),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .shot (take & (op == 2'b01) & hit),
            .cont (take & (op == 2'b10) & hit),
            .stop (take & ((op == 2'b11) | ((op == 2'b00) & hit))),
            .trig (trig[i]),
            .busy (busy[i])
        );
    end
endmodule
